otter_cu_fsm: RTL
=================

# otter_cu_fsm

Multicycle control-unit state machine for the OTTER RV32I core. It sequences each instruction through fetch, execute and optional load writeback, and drives the datapath enables: PC, register file, data memory, CSR file and interrupt entry. It sits beside the decoder and immediate generator, and consumes only the opcode and funct3 fields of the instruction register.

## Interface
- `OPC_W`, default 7: opcode field width; must be 7.
- `CLK` input 1: rising-edge clock.
- `RST_N` input 1: asynchronous, active-low reset.
- `OPCODE` input OPC_W: IR[6:0], valid from EXEC onward.
- `FUNC3` input 3: IR[14:12].
- `INTR` input 1: level-sensitive external interrupt request.
- `MIE` input 1: CSR mstatus.MIE; interrupts are enabled when 1.
- `MEM_ACK` input 1: data memory completion for the current load or store, a single-cycle pulse.
- `PC_RST` output 1: forces PC to 0.
- `PC_WRITE` output 1: PC register load enable.
- `REG_WRITE` output 1: register file write enable.
- `MEM_RDEN1` output 1: instruction memory read enable.
- `MEM_RDEN2` output 1: data memory read enable.
- `MEM_WE2` output 1: data memory write enable.
- `CSR_WE` output 1: CSR write enable (csrrw).
- `MRET_EXEC` output 1: selects mepc and restores MIE.
- `INT_TAKEN` output 1: selects mtvec, saves mepc and clears MIE.
- `STATE` output 3: debug view of the state. INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4.

## Operation
- Five states: INIT, FETCH, EXEC, WB, INTR. The state register resets asynchronously to INIT.
- All outputs are combinational from the state, OPCODE, FUNC3 and MEM_ACK. Any output not listed for a state is 0.
- **INIT**
  - PC_RST=1.
  - Next state is FETCH.
- **FETCH**
  - MEM_RDEN1=1.
  - Next state is EXEC. The instruction memory is synchronous, so IR is valid in EXEC.
- **EXEC**, decoded by OPCODE:
  - LOAD (0000011): MEM_RDEN2=1. Next state is WB.
  - STORE (0100011): MEM_WE2=1 every cycle until MEM_ACK=1. Stay in EXEC while MEM_ACK=0. In the ack cycle, PC_WRITE=1 and the instruction completes.
  - BRANCH (1100011): PC_WRITE=1 and the instruction completes.
  - LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111), OP-IMM (0010011), OP (0110011): REG_WRITE=1 and PC_WRITE=1, then complete.
  - SYSTEM (1110011) with FUNC3=001: CSR_WE=1, REG_WRITE=1, PC_WRITE=1, then complete.
  - SYSTEM with FUNC3=000 (mret): MRET_EXEC=1, PC_WRITE=1, then complete.
  - Any other opcode or SYSTEM funct3: PC_WRITE=1 only, so it executes as a NOP, then complete.
- **WB**
  - MEM_RDEN2=1 while MEM_ACK=0, and the state holds.
  - In the ack cycle: REG_WRITE=1 and PC_WRITE=1, then complete.
- **Completion rule**
  - If INTR=1 and MIE=1 in the completing cycle, the next state is INTR. Otherwise it is FETCH.
  - mret never chains directly into INTR. The next state after an mret is always FETCH, even when INTR=1.
- **INTR**
  - INT_TAKEN=1 and PC_WRITE=1.
  - Next state is FETCH unconditionally. Nested interrupts are not taken, because the datapath clears MIE.
- INTR asserted mid-instruction (in FETCH, during a store wait, or in WB) has no effect until completion.
- MEM_ACK outside the EXEC-store and WB states is ignored.

## Timing
- Reset: while RST_N=0, STATE=0 and PC_RST=1, and every other output is 0.
- Reset deassertion: the first edge moves to FETCH. Reset asserted in any state returns the FSM to INIT immediately, with no clock needed.
- ALU, branch, jump and CSR instructions take 2 cycles (FETCH, EXEC).
- Loads take 3+N cycles: FETCH, EXEC, then WB for N≥0 extra wait cycles. With ack in the first WB cycle, a load takes 3 cycles.
- Stores take 2+N cycles.
- Interrupt entry adds 1 cycle (INTR).
- Exactly one PC_WRITE pulse occurs per instruction and one per interrupt entry. REG_WRITE and MEM_WE2 are never both 1.

## Test plan
- Reset check: hold RST_N=0 for 3 cycles, then release. Required: STATE=0 and PC_RST=1 during reset. STATE sequence after release is 1, 2, 1, 2… with OPCODE=0010011. PC_WRITE=1 and REG_WRITE=1 only in EXEC.
- Load with delay: OPCODE=0000011 and MEM_ACK delayed 2 cycles. Required: EXEC has MEM_RDEN2=1; WB lasts 3 cycles. REG_WRITE and PC_WRITE equal 1 only in the ack cycle. Total is 5 cycles.
- Store with immediate ack: OPCODE=0100011 and MEM_ACK=1 in the first EXEC cycle. Required: MEM_WE2=1 and PC_WRITE=1 in the same cycle, REG_WRITE=0, next STATE=1.
- Interrupt gating: with INTR=1 and MIE=1 during an OP instruction, the next state after EXEC is 4 and INT_TAKEN=1 for 1 cycle, then STATE=1. Repeat with MIE=0: required next state is 1, no INT_TAKEN.
- mret with pending interrupt: OPCODE=1110011, FUNC3=000, INTR=1. Required: MRET_EXEC=1, PC_WRITE=1, next state 1, not 4. CSR_WE=0.
- Mid-operation reset: assert RST_N=0 in WB, between clock edges. Required: STATE=0 and MEM_RDEN2=0 immediately, with no edge needed.

Source files
------------

// File: rtl/otter_cu_fsm.sv
// Multicycle control FSM for the OTTER RV32I core: sequences fetch, execute and
// load writeback, and drives the PC, register file, memory, CSR and interrupt enables.
module otter_cu_fsm #(
    parameter int OPC_W = 7
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [OPC_W-1:0] OPCODE,
    input  logic [2:0]       FUNC3,
    input  logic             INTR,
    input  logic             MIE,
    input  logic             MEM_ACK,
    output logic             PC_RST,
    output logic             PC_WRITE,
    output logic             REG_WRITE,
    output logic             MEM_RDEN1,
    output logic             MEM_RDEN2,
    output logic             MEM_WE2,
    output logic             CSR_WE,
    output logic             MRET_EXEC,
    output logic             INT_TAKEN,
    output logic [2:0]       STATE
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LOAD   = OPC_W'(7'b0000011);
    localparam logic [OPC_W-1:0] OPC_STORE  = OPC_W'(7'b0100011);
    localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(7'b1100011);
    localparam logic [OPC_W-1:0] OPC_LUI    = OPC_W'(7'b0110111);
    localparam logic [OPC_W-1:0] OPC_AUIPC  = OPC_W'(7'b0010111);
    localparam logic [OPC_W-1:0] OPC_JAL    = OPC_W'(7'b1101111);
    localparam logic [OPC_W-1:0] OPC_JALR   = OPC_W'(7'b1100111);
    localparam logic [OPC_W-1:0] OPC_OPIMM  = OPC_W'(7'b0010011);
    localparam logic [OPC_W-1:0] OPC_OP     = OPC_W'(7'b0110011);
    localparam logic [OPC_W-1:0] OPC_SYSTEM = OPC_W'(7'b1110011);

    state_t state;
    state_t state_nxt;
    logic   done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        PC_RST    = 1'b0;
        PC_WRITE  = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        MRET_EXEC = 1'b0;
        INT_TAKEN = 1'b0;
        done      = 1'b0;
        state_nxt = state;

        case (state)
            ST_INIT: begin
                PC_RST    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                case (OPCODE)
                    OPC_LOAD: begin
                        MEM_RDEN2 = 1'b1;
                        state_nxt = ST_WB;
                    end
                    OPC_STORE: begin
                        MEM_WE2 = 1'b1;
                        if (MEM_ACK) begin
                            PC_WRITE = 1'b1;
                            done     = 1'b1;
                        end
                    end
                    OPC_BRANCH: begin
                        PC_WRITE = 1'b1;
                        done     = 1'b1;
                    end
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OP: begin
                        REG_WRITE = 1'b1;
                        PC_WRITE  = 1'b1;
                        done      = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        PC_WRITE = 1'b1;
                        if (FUNC3 == 3'b001) begin
                            CSR_WE    = 1'b1;
                            REG_WRITE = 1'b1;
                            done      = 1'b1;
                        end else if (FUNC3 == 3'b000) begin
                            // mret returns to the interrupted code before any new interrupt is taken
                            MRET_EXEC = 1'b1;
                            state_nxt = ST_FETCH;
                        end else begin
                            done = 1'b1;
                        end
                    end
                    default: begin
                        PC_WRITE = 1'b1;
                        done     = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                if (MEM_ACK) begin
                    REG_WRITE = 1'b1;
                    PC_WRITE  = 1'b1;
                    done      = 1'b1;
                end else begin
                    MEM_RDEN2 = 1'b1;
                end
            end
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_INIT;
        endcase

        if (done)
            state_nxt = (INTR && MIE) ? ST_INTR : ST_FETCH;
    end

    assign STATE = state;

endmodule
